// File: rtl/netdma_pkg.sv
// Shared types and default widths for the DMA completion-report path.
package netdma_pkg;

  localparam int unsigned DefDescIdW   = 8;
  localparam int unsigned DefByteCntW  = 16;
  localparam int unsigned DefBeatBytesW = 4;
  localparam int unsigned DefErrW      = 4;
  localparam int unsigned DefFifoDepth = 16;

  typedef struct packed {
    logic                   err;
    logic [DefErrW-1:0]     err_code;
    logic [DefDescIdW-1:0]  desc_id;
    logic [DefByteCntW-1:0] byte_cnt;
  } report_t;

  typedef enum logic {
    IRQ_IDLE_S,
    IRQ_ASSERTED_S
  } irq_state_t;

endpackage

// File: rtl/netdma_report_builder_if.sv
// Beat stream, report FIFO host port and interrupt signals of the report builder.
interface netdma_report_builder_if #(
  parameter int unsigned DESC_ID_W    = netdma_pkg::DefDescIdW,
  parameter int unsigned BYTE_CNT_W   = netdma_pkg::DefByteCntW,
  parameter int unsigned BEAT_BYTES_W = netdma_pkg::DefBeatBytesW,
  parameter int unsigned ERR_W        = netdma_pkg::DefErrW,
  parameter int unsigned FIFO_DEPTH   = netdma_pkg::DefFifoDepth
);
  localparam int unsigned ReportW = 1 + ERR_W + DESC_ID_W + BYTE_CNT_W;
  localparam int unsigned UsedW   = $clog2(FIFO_DEPTH) + 1;

  logic                    make_report_i;
  logic [DESC_ID_W-1:0]    desc_id_i;
  logic                    beat_valid_i;
  logic [BEAT_BYTES_W-1:0] beat_bytes_i;
  logic                    error_i;
  logic [ERR_W-1:0]        error_code_i;
  logic                    report_rd_i;
  logic [ReportW-1:0]      report_data_o;
  logic                    report_empty_o;
  logic [UsedW-1:0]        report_used_o;
  logic                    overflow_o;
  logic                    overflow_clr_i;
  logic                    irq_o;
  logic                    irq_ack_i;

  modport master (
    output make_report_i, desc_id_i, beat_valid_i, beat_bytes_i, error_i, error_code_i,
    output report_rd_i, overflow_clr_i, irq_ack_i,
    input  report_data_o, report_empty_o, report_used_o, overflow_o, irq_o
  );

  modport slave (
    input  make_report_i, desc_id_i, beat_valid_i, beat_bytes_i, error_i, error_code_i,
    input  report_rd_i, overflow_clr_i, irq_ack_i,
    output report_data_o, report_empty_o, report_used_o, overflow_o, irq_o
  );
endinterface

// File: rtl/netdma_report_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit to tell full from empty.
module netdma_report_fifo #(
  parameter int unsigned Width = 29,
  parameter int unsigned Depth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wrreq_i,
  input  logic                    rdreq_i,
  input  logic [Width-1:0]        data_i,
  output logic [Width-1:0]        q_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(Depth):0]  used_o
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_rd, do_wr;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
              (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    used_o  = wr_ptr_q - rd_ptr_q;
    do_rd   = rdreq_i && !empty_o;
    // A pop frees the slot this cycle, so a push to a full FIFO is still accepted.
    do_wr   = wrreq_i && (!full_o || do_rd);
    q_o     = mem_q[rd_ptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end
endmodule

// File: rtl/netdma_report_builder.sv
// Accumulates per-transfer byte count and first error, queues completion reports for the
// host and raises a coalesced level interrupt (threshold or timeout) with explicit ack.
module netdma_report_builder
  import netdma_pkg::*;
#(
  parameter int unsigned DESC_ID_W    = DefDescIdW,
  parameter int unsigned BYTE_CNT_W   = DefByteCntW,
  parameter int unsigned BEAT_BYTES_W = DefBeatBytesW,
  parameter int unsigned ERR_W        = DefErrW,
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth,
  parameter int unsigned IRQ_THRESH   = 4,
  parameter int unsigned IRQ_TIMEOUT  = 1024
) (
  input logic                    clk_i,
  input logic                    rst_i,
  netdma_report_builder_if.slave bus
);
  localparam int unsigned ReportW = 1 + ERR_W + DESC_ID_W + BYTE_CNT_W;
  localparam int unsigned UsedW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TimerW  = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [UsedW-1:0]  ThreshU     = UsedW'(IRQ_THRESH);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(IRQ_TIMEOUT - 1);

  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_sat;
  logic [BYTE_CNT_W:0]   byte_sum;
  logic                  err_q, err_d;
  logic [ERR_W-1:0]      err_code_q, err_code_d, err_code_rep;
  logic [ReportW-1:0]    report;
  logic                  fifo_empty, fifo_full;
  logic [UsedW-1:0]      fifo_used;
  logic                  overflow_q, overflow_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  irq_state_t            irq_state_q, irq_state_d;
  logic                  irq_cond;

  // The beat and error seen in the make_report cycle still belong to the closing transfer.
  always_comb begin
    byte_sum     = {1'b0, byte_cnt_q} +
                   (BYTE_CNT_W + 1)'(bus.beat_valid_i ? bus.beat_bytes_i : '0);
    byte_cnt_sat = byte_sum[BYTE_CNT_W] ? '1 : byte_sum[BYTE_CNT_W-1:0];
    err_code_rep = err_q ? err_code_q : (bus.error_i ? bus.error_code_i : '0);
    report       = {err_q | bus.error_i, err_code_rep, bus.desc_id_i, byte_cnt_sat};

    byte_cnt_d = byte_cnt_sat;
    err_d      = err_q;
    err_code_d = err_code_q;
    if (bus.make_report_i) begin
      byte_cnt_d = '0;
      err_d      = 1'b0;
      err_code_d = '0;
    end else if (bus.error_i && !err_q) begin
      err_d      = 1'b1;
      err_code_d = bus.error_code_i;
    end
  end

  netdma_report_fifo #(
    .Width(ReportW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wrreq_i(bus.make_report_i),
    .rdreq_i(bus.report_rd_i),
    .data_i (report),
    .q_o    (bus.report_data_o),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .used_o (fifo_used)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (bus.make_report_i && fifo_full && !bus.report_rd_i) overflow_d = 1'b1;
    else if (bus.overflow_clr_i)                            overflow_d = 1'b0;

    irq_cond = (fifo_used >= ThreshU) || (!fifo_empty && (timer_q == TimeoutLast));
    timer_d  = (fifo_empty || irq_state_q == IRQ_ASSERTED_S) ? '0 : timer_q + TimerW'(1);

    irq_state_d = irq_state_q;
    unique case (irq_state_q)
      IRQ_IDLE_S:     if (irq_cond) irq_state_d = IRQ_ASSERTED_S;
      IRQ_ASSERTED_S: if (bus.irq_ack_i) irq_state_d = IRQ_IDLE_S;
      default:        irq_state_d = IRQ_IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      overflow_q  <= 1'b0;
      timer_q     <= '0;
      irq_state_q <= IRQ_IDLE_S;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      overflow_q  <= overflow_d;
      timer_q     <= timer_d;
      irq_state_q <= irq_state_d;
    end
  end

  assign bus.report_empty_o = fifo_empty;
  assign bus.report_used_o  = fifo_used;
  assign bus.overflow_o     = overflow_q;
  assign bus.irq_o          = (irq_state_q == IRQ_ASSERTED_S);
endmodule
